// File: rtl/dbg_pkg.sv
// Shared definitions for the debug register-access path.
// Contents: command op encodings, master FSM state enum, default widths,
// and a helper that classifies a command as legal.
package dbg_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HALT   = 3'd1,
      ST_ACCESS = 3'd2,
      ST_VERIFY = 3'd3,
      ST_RESP   = 3'd4
   } dbg_state_e;

   // Reads are always legal; writes are legal except to the hardwired-zero register.
   function automatic logic cmd_is_legal(input logic [1:0] op, input logic addr_is_zero);
      return (op == OP_READ) || ((op == OP_WRITE) && !addr_is_zero);
   endfunction

endpackage

// File: rtl/dbg_halt_ctrl.sv
// Core halt handshake for the debug master.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_start         pulse: a legal command was accepted, raise halt request
//   i_in_halt       master is waiting for the core to halt
//   i_release       pulse: response handshake, drop halt request
//   i_halted        core reports halted
//   o_halt_req      registered halt request to the core
//   o_done_c        core halted while waiting (combinational)
//   o_timeout_c     wait budget exhausted without halt (combinational)
module dbg_halt_ctrl #(
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   input  logic i_in_halt,
   input  logic i_release,
   input  logic i_halted,
   output logic o_halt_req,
   output logic o_done_c,
   output logic o_timeout_c
);

   localparam int unsigned CNT_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_halt_req;

   assign o_done_c    = i_in_halt && i_halted;
   assign o_timeout_c = i_in_halt && !i_halted && (r_cnt == CNT_LAST);
   assign o_halt_req  = r_halt_req;

   // Wait counter: runs only while waiting, restarts on every exit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_in_halt && !o_done_c && !o_timeout_c) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   // Halt request held from accept through the response handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_halt_req <= 1'b0;
      end else if (i_start) begin
         r_halt_req <= 1'b1;
      end else if (i_release) begin
         r_halt_req <= 1'b0;
      end
   end

endmodule

// File: rtl/jtag_reg_master.sv
// Debug-side initiator for the register file's JTAG access port.
// Accepts one read/write command at a time, halts the core, performs the
// access (writes are verified by readback) and returns data plus status.
// Ports:
//   cmd_*        command channel (valid/ready), op 01 = read, 10 = write
//   rsp_*        response channel (valid/ready), data and error flag
//   halt_req_o / halted_i   core halt handshake
//   core_wr_en_i            core write-back active; core owns the port that cycle
//   jtag_en_o / jtag_add_o / jtag_data_o / jtag_rdata_i   register-file debug port
module jtag_reg_master
   import dbg_pkg::*;
#(
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              halt_req_o,
   input  logic              halted_i,
   input  logic              core_wr_en_i,
   output logic              jtag_en_o,
   output logic [ADDR_W-1:0] jtag_add_o,
   output logic [DATA_W-1:0] jtag_data_o,
   input  logic [DATA_W-1:0] jtag_rdata_i
);

   dbg_state_e        r_state;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
   logic [ADDR_W-1:0] r_jtag_add;
   logic [DATA_W-1:0] r_jtag_data;

   logic w_accept;
   logic w_legal;
   logic w_start;
   logic w_in_halt;
   logic w_rsp_hs;
   logic w_done;
   logic w_timeout;

   assign w_accept  = (r_state == ST_IDLE) && cmd_valid_i && r_cmd_ready;
   assign w_legal   = cmd_is_legal(cmd_op_i, cmd_addr_i == '0);
   assign w_start   = w_accept && w_legal;
   assign w_in_halt = (r_state == ST_HALT);
   assign w_rsp_hs  = (r_state == ST_RESP) && rsp_ready_i;

   dbg_halt_ctrl #(
      .HALT_TIMEOUT (HALT_TIMEOUT)
   ) u_halt_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_start),
      .i_in_halt   (w_in_halt),
      .i_release   (w_rsp_hs),
      .i_halted    (halted_i),
      .o_halt_req  (halt_req_o),
      .o_done_c    (w_done),
      .o_timeout_c (w_timeout)
   );

   assign cmd_ready_o = r_cmd_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_err_o   = r_rsp_err;
   assign jtag_add_o  = r_jtag_add;
   assign jtag_data_o = r_jtag_data;

   // Write strobe is qualified in the same cycle by core_wr_en_i so the core
   // always wins the shared write port; a blocked cycle simply retries.
   assign jtag_en_o = (r_state == ST_ACCESS) && (r_op == OP_WRITE) && !core_wr_en_i;

   // Command FSM and datapath.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= 2'b00;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_jtag_add  <= '0;
         r_jtag_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op        <= cmd_op_i;
                  r_addr      <= cmd_addr_i;
                  r_wdata     <= cmd_data_i;
                  r_cmd_ready <= 1'b0;
                  if (w_legal) begin
                     r_state <= ST_HALT;
                  end else begin
                     // Rejected without touching the core.
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                     r_state     <= ST_RESP;
                  end
               end
            end

            ST_HALT: begin
               if (w_done) begin
                  r_jtag_add <= r_addr;
                  if (r_op == OP_WRITE) begin
                     r_jtag_data <= r_wdata;
                  end
                  r_state <= ST_ACCESS;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end

            ST_ACCESS: begin
               if (r_op == OP_WRITE) begin
                  if (!core_wr_en_i) begin
                     r_state <= ST_VERIFY;
                  end
               end else begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= jtag_rdata_i;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
               end
            end

            ST_VERIFY: begin
               // Readback after the write landed; any difference is reported.
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= jtag_rdata_i;
               r_rsp_err   <= (jtag_rdata_i != r_wdata);
               r_state     <= ST_RESP;
            end

            ST_RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_reg_master.sv
// Directed testbench for jtag_reg_master with a behavioural register file.
module tb_jtag_reg_master;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          halt_req;
   logic          halted;
   logic          core_wr_en;
   logic          jtag_en;
   logic [AW-1:0] jtag_add;
   logic [DW-1:0] jtag_data;
   logic [DW-1:0] jtag_rdata;

   // Register file model with optional stuck-at-0 on bit 0 and a bench preload port.
   logic [DW-1:0] mem [32];
   logic          stuck;
   logic          tb_we;
   logic [AW-1:0] tb_wa;
   logic [DW-1:0] tb_wd;
   int            en_cnt;
   int            halt_cnt;

   int n_chk;
   int n_fail;
   int lat;
   int en_base;
   int halt_base;

   always #5 clk = ~clk;

   jtag_reg_master #(
      .DATA_W       (DW),
      .ADDR_W       (AW),
      .HALT_TIMEOUT (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_op_i     (cmd_op),
      .cmd_addr_i   (cmd_addr),
      .cmd_data_i   (cmd_data),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_data_o   (rsp_data),
      .rsp_err_o    (rsp_err),
      .halt_req_o   (halt_req),
      .halted_i     (halted),
      .core_wr_en_i (core_wr_en),
      .jtag_en_o    (jtag_en),
      .jtag_add_o   (jtag_add),
      .jtag_data_o  (jtag_data),
      .jtag_rdata_i (jtag_rdata)
   );

   assign jtag_rdata = mem[jtag_add];

   always @(posedge clk) begin
      if (jtag_en === 1'b1) begin
         mem[jtag_add] <= stuck ? (jtag_data & ~32'h1) : jtag_data;
         en_cnt        <= en_cnt + 1;
      end else if (tb_we) begin
         mem[tb_wa] <= tb_wd;
      end
      if (halt_req === 1'b1) halt_cnt <= halt_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Cycles from accept until rsp_valid, bounded.
   task automatic wait_rsp(output int l);
      l = 1;
      while (rsp_valid !== 1'b1 && l < 40) begin
         @(negedge clk);
         l++;
      end
      chk("rsp_valid_arrives", 64'(rsp_valid), 64'd1);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("hs_halt_req",  64'(halt_req),  64'd0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
      rsp_ready = 1'b0; halted = 1'b1; core_wr_en = 1'b0; stuck = 1'b0;
      tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_halt_req",  64'(halt_req),  64'd0);
      chk("rst_jtag_en",   64'(jtag_en),   64'd0);
      chk("rst_jtag_add",  64'(jtag_add),  64'd0);
      chk("rst_jtag_data", 64'(jtag_data), 64'd0);

      tb_we = 1'b1; tb_wa = 5'd5; tb_wd = 32'hDEADBEEF;
      @(negedge clk);
      tb_we = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // 1: read x5, core already halted, 3-cycle latency
      send_cmd(2'b01, 5'd5, 32'h0);
      chk("rd_cmd_ready_busy", 64'(cmd_ready), 64'd0);
      chk("rd_halt_req",       64'(halt_req),  64'd1);
      wait_rsp(lat);
      chk("rd_latency", 64'(lat),      64'd3);
      chk("rd_data",    64'(rsp_data), 64'hDEADBEEF);
      chk("rd_err",     64'(rsp_err),  64'd0);
      handshake();
      chk("rd_add_hold", 64'(jtag_add), 64'd5);

      // 2: write x7 blocked by core write-back for 4 cycles
      en_base = en_cnt;
      core_wr_en = 1'b1;
      send_cmd(2'b10, 5'd7, 32'h12345678);
      repeat (3) @(negedge clk);
      chk("wr_blocked_en",   64'(jtag_en),          64'd0);
      chk("wr_blocked_cnt",  64'(en_cnt - en_base), 64'd0);
      chk("wr_add",          64'(jtag_add),         64'd7);
      chk("wr_data",         64'(jtag_data),        64'h12345678);
      core_wr_en = 1'b0;
      wait_rsp(lat);
      chk("wr_en_pulses",  64'(en_cnt - en_base), 64'd1);
      chk("wr_rsp_data",   64'(rsp_data),         64'h12345678);
      chk("wr_rsp_err",    64'(rsp_err),          64'd0);
      handshake();

      // 3a: write to x0 rejected without halt
      en_base = en_cnt; halt_base = halt_cnt;
      send_cmd(2'b10, 5'd0, 32'h1);
      wait_rsp(lat);
      chk("x0_latency", 64'(lat),      64'd1);
      chk("x0_err",     64'(rsp_err),  64'd1);
      chk("x0_data",    64'(rsp_data), 64'd0);
      handshake();
      chk("x0_no_halt", 64'(halt_cnt - halt_base), 64'd0);
      chk("x0_no_en",   64'(en_cnt - en_base),     64'd0);

      // 3b: illegal op 11
      en_base = en_cnt; halt_base = halt_cnt;
      send_cmd(2'b11, 5'd3, 32'hA5A5A5A5);
      wait_rsp(lat);
      chk("ill_err",  64'(rsp_err),  64'd1);
      chk("ill_data", 64'(rsp_data), 64'd0);
      handshake();
      chk("ill_no_halt", 64'(halt_cnt - halt_base), 64'd0);
      chk("ill_no_en",   64'(en_cnt - en_base),     64'd0);

      // 4: halt timeout after 8 HALT cycles
      en_base = en_cnt;
      halted = 1'b0;
      send_cmd(2'b10, 5'd9, 32'h55);
      wait_rsp(lat);
      chk("to_latency",  64'(lat),              64'd9);
      chk("to_err",      64'(rsp_err),          64'd1);
      chk("to_data",     64'(rsp_data),         64'd0);
      chk("to_halt_req", 64'(halt_req),         64'd1);
      chk("to_no_en",    64'(en_cnt - en_base), 64'd0);
      handshake();
      halted = 1'b1;

      // 5: stuck bit 0 corrupts the write; 6a: response held under back-pressure
      stuck = 1'b1;
      send_cmd(2'b10, 5'd9, 32'hFF);
      wait_rsp(lat);
      chk("stk_data", 64'(rsp_data), 64'hFE);
      chk("stk_err",  64'(rsp_err),  64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid",     64'(rsp_valid), 64'd1);
         chk("bp_data",      64'(rsp_data),  64'hFE);
         chk("bp_err",       64'(rsp_err),   64'd1);
         chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      handshake();
      stuck = 1'b0;

      // 6b: reset while waiting for halt abandons the command
      en_base = en_cnt;
      halted = 1'b0;
      send_cmd(2'b10, 5'd4, 32'h77);
      repeat (2) @(negedge clk);
      chk("mid_halt_req", 64'(halt_req), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mr_halt_req",  64'(halt_req),  64'd0);
      chk("mr_jtag_en",   64'(jtag_en),   64'd0);
      chk("mr_jtag_add",  64'(jtag_add),  64'd0);
      chk("mr_rsp_data",  64'(rsp_data),  64'd0);
      chk("mr_rsp_err",   64'(rsp_err),   64'd0);
      rst_n = 1'b1;
      halted = 1'b1;
      repeat (10) @(negedge clk);
      chk("mr_no_rsp", 64'(rsp_valid),        64'd0);
      chk("mr_no_en",  64'(en_cnt - en_base), 64'd0);

      // Recovery: x7 still holds the earlier write
      send_cmd(2'b01, 5'd7, 32'h0);
      wait_rsp(lat);
      chk("rec_latency", 64'(lat),      64'd3);
      chk("rec_data",    64'(rsp_data), 64'h12345678);
      chk("rec_err",     64'(rsp_err),  64'd0);
      handshake();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
